// File: rtl/imem_fetch_unit.sv
// ----------------------------------------------------------------------------
// imem_fetch_unit: loadable instruction memory behind a fetch request/response
// handshake. Optional alignment faulting via IMEM_ALIGN_CHECK_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module imem_fetch_unit #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 64,
  parameter logic [31:0]       BASE_ADDR = 32'h0000_0004,
  parameter int                READ_LAT  = 1,
  parameter logic [DATA_W-1:0] FILL_WORD = 32'h1234_abcd
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              load_we,
  input  logic [31:0]       load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 3;
`ifdef IMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, RESP = 2'd2} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     idx_q;
  logic              fault_q;
  logic [DATA_W-1:0] rdata;
  logic              rerr;
  logic [DATA_W-1:0] mem [DEPTH];

  // Range check on the byte offset keeps every offset bit in the compare.
  logic [31:0] f_off, l_off;
  logic        f_fault, l_fault, mem_we;

  assign f_off   = fetch_addr - BASE_ADDR;
  assign l_off   = load_addr - BASE_ADDR;
  assign f_fault = !((fetch_addr >= BASE_ADDR) && (f_off < 32'(DEPTH * 4)))
                   || (ALIGN_CHECK && (fetch_addr[1:0] != 2'b00));
  assign l_fault = !((load_addr >= BASE_ADDR) && (l_off < 32'(DEPTH * 4)))
                   || (ALIGN_CHECK && (load_addr[1:0] != 2'b00));

  assign fetch_ready = (state == IDLE) && !load_we;
  assign load_ready  = (state == IDLE);

  // A write presented while reset is asserted must not land in the array.
  assign mem_we = !reset && (state == IDLE) && load_we && !l_fault;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[l_off[AW+1:2]] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx_q       <= '0;
      fault_q     <= 1'b0;
      rdata       <= '0;
      rerr        <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_data  <= '0;
      load_err    <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      load_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (load_we) begin
            load_err <= l_fault;
          end else if (fetch_req) begin
            idx_q   <= f_off[AW+1:2];
            fault_q <= f_fault;
            cnt     <= CW'(READ_LAT - 1);
            state   <= READ;
          end
        end
        READ: begin
          if (cnt == '0) begin
            rdata <= fault_q ? FILL_WORD : mem[idx_q];
            rerr  <= fault_q;
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          fetch_valid <= 1'b1;
          fetch_data  <= rdata;
          fetch_err   <= rerr;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_imem_fetch_unit: directed bench for imem_fetch_unit at READ_LAT 1 and 4.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_imem_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_req, a_we, a_fready, a_valid, a_ferr, a_lready, a_lerr;
  logic [31:0] a_addr, a_laddr, a_ldata, a_data;
  logic        b_req, b_we, b_fready, b_valid, b_ferr, b_lready, b_lerr;
  logic [31:0] b_addr, b_laddr, b_ldata, b_data;

  int passed = 0;
  int total  = 0;
  int failed = 0;

`ifdef IMEM_ALIGN_CHECK_EN
  localparam logic [31:0] EXP_MIS_DATA = 32'h1234_abcd;
  localparam logic [31:0] EXP_MIS_ERR  = 32'd1;
  localparam logic [31:0] EXP_IDX1     = 32'hAC02_1010;
`else
  localparam logic [31:0] EXP_MIS_DATA = 32'h0063_1820;
  localparam logic [31:0] EXP_MIS_ERR  = 32'd0;
  localparam logic [31:0] EXP_IDX1     = 32'hDEAD_BEEF;
`endif

  imem_fetch_unit #(.READ_LAT(1)) dut_a (
    .clk(clk), .reset(reset),
    .fetch_req(a_req), .fetch_addr(a_addr), .fetch_ready(a_fready),
    .fetch_valid(a_valid), .fetch_data(a_data), .fetch_err(a_ferr),
    .load_we(a_we), .load_addr(a_laddr), .load_data(a_ldata),
    .load_ready(a_lready), .load_err(a_lerr)
  );

  imem_fetch_unit #(.READ_LAT(4)) dut_b (
    .clk(clk), .reset(reset),
    .fetch_req(b_req), .fetch_addr(b_addr), .fetch_ready(b_fready),
    .fetch_valid(b_valid), .fetch_data(b_data), .fetch_err(b_ferr),
    .load_we(b_we), .load_addr(b_laddr), .load_data(b_ldata),
    .load_ready(b_lready), .load_err(b_lerr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input string tag);
    a_we = 1'b1; a_laddr = a; a_ldata = d;
    #1;
    chk({tag, "_lready"}, 32'(a_lready), 32'd1);
    tick;
    a_we = 1'b0;
    chk({tag, "_lerr"}, 32'(a_lerr), 32'(exp_err));
    tick;
    chk({tag, "_lerr_clr"}, 32'(a_lerr), 32'd0);
  endtask

  task automatic fetch_a(input logic [31:0] a, input logic [31:0] ed,
                         input logic ee, input string tag);
    int n;
    a_req = 1'b1; a_addr = a;
    #1;
    chk({tag, "_fready"}, 32'(a_fready), 32'd1);
    tick;
    a_req = 1'b0;
    n = 0;
    while (a_valid !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd2);
    chk({tag, "_data"}, a_data, ed);
    chk({tag, "_err"}, 32'(a_ferr), 32'(ee));
    tick;
    chk({tag, "_pulse"}, 32'(a_valid), 32'd0);
  endtask

  task automatic fetch_b(input logic [31:0] a, input logic [31:0] ed,
                         input logic ee, input string tag);
    int n;
    b_req = 1'b1; b_addr = a;
    #1;
    tick;
    b_req = 1'b0;
    n = 0;
    while (b_valid !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd5);
    chk({tag, "_data"}, b_data, ed);
    chk({tag, "_err"}, 32'(b_ferr), 32'(ee));
  endtask

  initial begin
    int n;
    reset = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_laddr = 0; a_ldata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_laddr = 0; b_ldata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_ferr", 32'(a_ferr), 32'd0);
    chk("rst_lerr", 32'(a_lerr), 32'd0);
    chk("rst_data", a_data, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_fready", 32'(a_fready), 32'd1);
    chk("rst_lready", 32'(a_lready), 32'd1);

    // Program load and basic fetches.
    load_a(32'h4, 32'h0063_1820, 1'b0, "ld4");
    load_a(32'h8, 32'hAC02_1010, 1'b0, "ld8");
    load_a(32'h100, 32'hCAFE_F00D, 1'b0, "ld_last");
    load_a(32'h0, 32'h5555_5555, 1'b1, "ld_unmapped");
    fetch_a(32'h4, 32'h0063_1820, 1'b0, "f4");
    fetch_a(32'h8, 32'hAC02_1010, 1'b0, "f8");
    fetch_a(32'h100, 32'hCAFE_F00D, 1'b0, "f_last");
    fetch_a(32'h0, 32'h1234_abcd, 1'b1, "f_below");
    fetch_a(32'h104, 32'h1234_abcd, 1'b1, "f_above");

    // Misaligned accesses.
    fetch_a(32'h6, EXP_MIS_DATA, EXP_MIS_ERR[0], "f_mis");
    load_a(32'hA, 32'hDEAD_BEEF, EXP_MIS_ERR[0], "ld_mis");
    fetch_a(32'h8, EXP_IDX1, 1'b0, "f8_after_mis");

    // Load and fetch in the same idle cycle: load wins.
    a_we = 1'b1; a_laddr = 32'hC; a_ldata = 32'h1111_2222;
    a_req = 1'b1; a_addr = 32'hC;
    #1;
    chk("coll_fready", 32'(a_fready), 32'd0);
    chk("coll_lready", 32'(a_lready), 32'd1);
    tick;
    a_we = 1'b0;
    chk("coll_lerr", 32'(a_lerr), 32'd0);
    fetch_a(32'hC, 32'h1111_2222, 1'b0, "coll_fetch");

    // READ_LAT=4: loads during READ are ignored.
    b_we = 1'b1; b_laddr = 32'h10; b_ldata = 32'h5566_7788;
    #1;
    tick;
    b_we = 1'b0;
    chk("b_ld_lerr", 32'(b_lerr), 32'd0);
    b_req = 1'b1; b_addr = 32'h10;
    #1;
    chk("b_fready", 32'(b_fready), 32'd1);
    tick;
    b_req = 1'b0;
    b_we = 1'b1; b_laddr = 32'h10; b_ldata = 32'h9999_9999;
    #1;
    chk("b_read_lready", 32'(b_lready), 32'd0);
    chk("b_read_fready", 32'(b_fready), 32'd0);
    tick;
    chk("b_read_lerr1", 32'(b_lerr), 32'd0);
    b_laddr = 32'h0;
    tick;
    b_we = 1'b0;
    chk("b_read_lerr2", 32'(b_lerr), 32'd0);
    n = 2;
    while (b_valid !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk("b_lat", 32'(n), 32'd5);
    chk("b_data", b_data, 32'h5566_7788);
    chk("b_err", 32'(b_ferr), 32'd0);
    tick;
    chk("b_lerr_after", 32'(b_lerr), 32'd0);
    fetch_b(32'h10, 32'h5566_7788, 1'b0, "b_refetch");
    tick;
    fetch_b(32'h0, 32'h1234_abcd, 1'b1, "b_fault");
    tick;

    // Reset in the middle of a READ aborts the fetch.
    a_req = 1'b1; a_addr = 32'h4;
    #1;
    tick;
    a_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_valid", 32'(a_valid), 32'd0);
    chk("mid_data", a_data, 32'd0);
    chk("mid_ferr", 32'(a_ferr), 32'd0);
    chk("mid_lerr", 32'(a_lerr), 32'd0);
    tick;
    tick;
    chk("mid_hold_valid", 32'(a_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_fready", 32'(a_fready), 32'd1);
    chk("post_lready", 32'(a_lready), 32'd1);
    tick;
    tick;
    chk("post_no_resp", 32'(a_valid), 32'd0);
    fetch_a(32'h4, 32'h0063_1820, 1'b0, "post_f4");
    fetch_a(32'hC, 32'h1111_2222, 1'b0, "post_fC");
    fetch_a(32'h100, 32'hCAFE_F00D, 1'b0, "post_last");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
